// File: rtl/icache_pkg.sv
// Shared widths and FSM state encoding for the direct-mapped instruction cache.
package icache_pkg;
  localparam int TAG_W      = 3;
  localparam int INDEX_W    = 3;
  localparam int WORD_W     = 2;
  localparam int BLOCK_W    = 128;
  localparam int MEM_ADDR_W = 6;
  localparam int NUM_LINES  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;
endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the cache lines: one write port, one combinational read port.
module icache_line_array
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_block,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [BLOCK_W-1:0]   data_q [NUM_LINES];
  logic [BLOCK_W-1:0]   data_d [NUM_LINES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (we) begin
      valid_d[wr_index] = 1'b1;
      tag_d[wr_index]   = wr_tag;
      data_d[wr_index]  = wr_block;
    end
  end

  // Only valid bits are cleared; tag/data contents are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller: hit logic, word mux, refill FSM, perf counters.
module icache_controller
  import icache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic [9:0]            address,
  output logic [31:0]           instruction,
  output logic                  busywait,
  output logic                  mem_read,
  output logic [MEM_ADDR_W-1:0] mem_address,
  input  logic [BLOCK_W-1:0]    mem_readinst,
  input  logic                  mem_busywait,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      miss_count,
  output state_t                state_dbg
);

  // Handshake: mem_read is held with a stable mem_address until memory reports
  // mem_busywait=0 on a cycle after the first; the CPU stalls while busywait=1.

  state_t                  state_q, state_d;
  logic                    first_q, first_d;
  logic                    mem_read_q, mem_read_d;
  logic [MEM_ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [CNT_W-1:0]        hit_count_q, hit_count_d;
  logic [CNT_W-1:0]        miss_count_q, miss_count_d;

  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] index;
  logic [WORD_W-1:0]  word;
  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [BLOCK_W-1:0] line_data;
  logic               hit;
  logic [31:0]        word_data;
  logic               unused_addr_bits;

  assign tag              = address[9:7];
  assign index            = address[6:4];
  assign word             = address[3:2];
  assign unused_addr_bits = ^address[1:0];

  icache_line_array u_lines (
    .clk      (clock),
    .rst_n    (reset),
    .we       (state_q == UPDATE),
    .wr_index (mem_address_q[INDEX_W-1:0]),
    .wr_tag   (mem_address_q[MEM_ADDR_W-1:INDEX_W]),
    .wr_block (mem_readinst),
    .rd_index (index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data)
  );

  assign hit       = line_valid && (line_tag == tag);
  assign word_data = line_data[{word, 5'b0} +: 32];

  always_comb begin
    state_d       = state_q;
    first_d       = 1'b0;
    mem_read_d    = mem_read_q;
    mem_address_d = mem_address_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    case (state_q)
      IDLE: begin
        if (read) begin
          if (hit) begin
            if (hit_count_q != '1) hit_count_d = hit_count_q + CNT_W'(1);
          end else begin
            if (miss_count_q != '1) miss_count_d = miss_count_q + CNT_W'(1);
            mem_address_d = {tag, index};
            mem_read_d    = 1'b1;
            first_d       = 1'b1;
            state_d       = MEM_READ;
          end
        end
      end
      // The entry cycle is ignored so memory has a chance to raise its busy flag.
      MEM_READ: begin
        if (!first_q && !mem_busywait) begin
          mem_read_d = 1'b0;
          state_d    = UPDATE;
        end
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      first_q       <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
    end
  end

  assign busywait    = read && ((state_q != IDLE) || !hit);
  assign instruction = (read && (state_q == IDLE) && hit) ? word_data : 32'h0;
  assign mem_read    = mem_read_q;
  assign mem_address = mem_address_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;
  assign state_dbg   = state_q;

endmodule

// File: doc/icache_controller.md
Name: icache_controller

Overview:
- Direct-mapped instruction cache controller between the CPU fetch stage and the 128-bit block instruction memory.
- Serves 32-bit instruction fetches from 8 cached 16-byte blocks.
- On a miss, sequences one block read from instruction memory using its read/busywait handshake, installs the block, then completes the fetch.
- Keeps saturating hit and miss counters for performance analysis.

Parameters:
- CNT_W, 16, width of the hit and miss performance counters.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset, sampled on posedge clock.
- read  input  1  CPU fetch request.
- address  input  10  CPU byte address of the fetch.
- instruction  output  32  fetched instruction word.
- busywait  output  1  CPU stall request.
- mem_read  output  1  block read request to instruction memory.
- mem_address  output  6  block address to instruction memory.
- mem_readinst  input  128  block data returned by instruction memory; byte 0 is in bits [7:0].
- mem_busywait  input  1  instruction memory busy flag.
- hit_count  output  CNT_W  number of completed hits, saturating.
- miss_count  output  CNT_W  number of misses, saturating.

Behaviour:
- Address split:
  - tag = address[9:7]
  - index = address[6:4]
  - word = address[3:2]
  - address[1:0] is ignored.
- Storage: 8 lines, each with valid (1 bit), tag (3 bits) and data (128 bits).
- Word select: word w of a line is data[32*w+31 : 32*w].
- hit = valid[index] AND tag[index] == tag, evaluated combinationally.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - read=1 with hit: instruction = selected word combinationally, busywait=0, hit_count increments at posedge. Zero-cycle latency.
  - read=1 with miss: busywait=1 combinationally. At posedge, latch {tag,index} into mem_address, set mem_read=1, increment miss_count, go to MEM_READ.
  - read=0: busywait=0 and instruction=0.
- MEM_READ:
  - mem_read=1 and mem_address hold the latched block.
  - Stay while mem_busywait=1 or on the first cycle after entry.
  - At the first posedge after entry where mem_busywait=0: drop mem_read, go to UPDATE.
- UPDATE:
  - At posedge, write mem_readinst into the line at the latched index; set that line's tag to the latched tag and valid=1.
  - mem_read=0; go to IDLE.
  - The next cycle re-evaluates the current address and normally hits. The hit counter counts that cycle; the miss cycle is not counted as a hit.
- busywait = read AND (state != IDLE OR NOT hit).
- Reset (reset=0 at posedge):
  - state=IDLE, all valid bits=0, mem_read=0, mem_address=0, hit_count=0, miss_count=0.
  - busywait and instruction then follow the combinational rules: 0 when read=0; a miss when read=1.
  - Reset during MEM_READ or UPDATE abandons the refill with no line written. Memory sees mem_read fall, and its own read detection clears.
- read dropped during MEM_READ: the refill still completes and the line is installed, so the memory handshake is never truncated.
- address changing during MEM_READ/UPDATE: has no effect on the refill, which always uses the latched index and tag.
- Counters saturate at all-ones and never wrap.
- Data and tag arrays are not reset; only valid is cleared.

Decomposition:
- icache_pkg holds:
  - widths TAG_W=3, INDEX_W=3, WORD_W=2, BLOCK_W=128, MEM_ADDR_W=6
  - NUM_LINES=8
  - state enum {IDLE, MEM_READ, UPDATE}
- Sub-module icache_line_array holds the valid/tag/data storage:
  - one write port: index, tag, block, write enable
  - one combinational read port: index -> valid, tag, data
  - synchronous active-low clear of the valid bits
- The controller holds the FSM, hit logic, word mux and counters.

Test Plan:
- Reset with read=0: after posedge with reset=0, mem_read=0, mem_address=0, busywait=0, instruction=0, both counters=0.
- Cold miss, read=1, address=0x004, memory block 0 = words {0x00A00093, 0x00100113, 0x002081B3, 0xFFDFF06F}:
  - busywait=1, mem_read=1, mem_address=0.
  - After mem_busywait falls: UPDATE, then IDLE, instruction=0x00100113, busywait=0.
  - miss_count=1.
- Hits at addresses 0x000, 0x008, 0x00C, 0x00E on consecutive cycles:
  - instructions 0x00A00093, 0x002081B3, 0xFFDFF06F, 0xFFDFF06F (low bits ignored).
  - busywait=0 throughout, mem_read never asserted.
  - hit_count = previous value + 4.
- Conflict miss at address 0x080 (index 0, tag 1):
  - refill with mem_address=8; line 0 replaced.
  - A re-fetch of 0x000 then misses again with mem_address=0.
- Fetch dropped mid-refill: read falls during MEM_READ → mem_read stays 1 until mem_busywait=0, line installed. A later read of the same address hits with no memory access.
- Reset mid-refill: reset=0 during MEM_READ → next cycle state=IDLE, mem_read=0, all lines invalid. The same address then misses again.
- Counter saturation: force hit_count near all-ones (or set CNT_W=4) and issue 20 hits → hit_count=15, no wrap.
